key_matrix_emu: RTL
===================

# key_matrix_emu

Synthesizable 3×4 keypad emulator that sits on the far side of the keypad scanner's column/row interface. It answers column strobes with row levels, so a key sequence can be injected without a physical keypad. Typical uses are on-board self-test and simulation of the scanner. Key codes arrive over a valid/ready handshake. Each code is pressed for a programmable number of scan rounds, then released for a programmable gap.

## Interface
Parameters:
- HOLD_SCANS, default 4: scan-round ticks a key is held. Legal range 2..255.
- GAP_SCANS, default 2: scan-round ticks of release after each key. Legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_code  in  4  key to press, using the codebase key codes: SN=0, SA(*)=1, SS(#)=2, S0..S9=3..12.
- key_valid  in  1  key_code is valid.
- key_ready  out  1  block can accept a code; asserted exactly when state is IDLE.
- key_col  in  3  one-hot column strobe from the scanner: 100, 010, 001.
- key_row  out  4  active-high row levels returned to the scanner.
- busy  out  1  asserted while state is PRESS or RELEASE.
- done  out  1  one-cycle pulse when a code's gap completes.

## Operation
- Key map, as row/column pairs:
  - row[3]: col 100=S1, col 010=S2, col 001=S3.
  - row[2]: S4, S5, S6.
  - row[1]: S7, S8, S9.
  - row[0]: SA, S0, SS.
- Codes 0 and 13..15 are accepted as pauses. No row activity occurs; the block goes straight to RELEASE.
- Scan tick: asserted when key_col==001 and the registered previous key_col (prev_col) != 001. Exactly one tick per scanner round.
- FSM states:
  - IDLE: key_ready=1. When key_valid=1, latch the code and clear the tick counter. A code of 1..12 goes to PRESS; any other code goes to RELEASE.
  - PRESS: pressed flag=1. Count ticks. When count reaches HOLD_SCANS, go to RELEASE, clear the counter and clear pressed.
  - RELEASE: key_row=0. Count ticks. When count reaches GAP_SCANS, go to IDLE and pulse done.
- key_row:
  - Equals the latched row one-hot when pressed=1 and key_col equals the latched column one-hot.
  - Otherwise 0, including when key_col is non-one-hot (000, 011, …).
- Tick counter: 8 bits, saturates at 255, compared with ==.
- A code is held for between HOLD_SCANS-1 and HOLD_SCANS full rounds, because the first round may be partial. This is why HOLD_SCANS must be at least 2.

## Timing
- Reset values: key_ready=1, key_row=0, busy=0, done=0. Also state=IDLE, pressed=0, prev_col=000, counter=0.
- Handshake: transfer happens on a rising edge where key_valid & key_ready. Holding key_code stable is not required after the transfer.
- Press latency: pressed rises one cycle after the transfer.
- key_row is combinational from key_col and registered state, with zero cycles of latency. The scanner changes columns on posedge and samples rows on negedge, so row levels must be valid within that half cycle.
- Release: pressed falls on the same edge as the PRESS→RELEASE transition. key_row is 0 from that cycle on.
- done is asserted in the first IDLE cycle, while key_ready=1. A new code presented in that cycle is accepted, so back-to-back sequences have no bubble.
- Simultaneous tick and transfer in IDLE: the tick is ignored, and counting starts from the next tick.
- Reset during PRESS or RELEASE: on the next edge key_row=0, busy=0, and no done pulse is issued. The latched code is discarded.

## Structure
- Shared package key_matrix_pkg:
  - key-code constants SN, SA, SS, S0..S9;
  - column one-hot constants COL_L=100, COL_M=010, COL_R=001;
  - FSM state enum.
  - The scanner and the emulator both use this package.
- Sub-module key_code_map: combinational decode of a 4-bit code into row one-hot, column one-hot, and a valid_key flag for codes 1..12.
- Top level: FSM, tick detector, counter, row gating.

## Test plan
Use a bench scanner model that rotates key_col 100→010→001 every cycle, with HOLD_SCANS=4 and GAP_SCANS=2.
1. Reset for 2 cycles → key_ready=1, busy=0, done=0, key_row=0000 for any key_col.
2. Send code 4 (S1) → key_row=1000 only while key_col=100. The scanner reports num=4, then num=0 after 4 ticks. done pulses 2 ticks after release.
3. Send code 2 (SS) → key_row=0001 only while key_col=001. Code 11 (S8) → key_row=0010 only while key_col=010.
4. Send code 0, then code 14 → key_row stays 0000. busy lasts 2 ticks each, and one done pulse per code.
5. Hold key_valid high with codes 12 then 3 queued → the second transfer occurs in the done cycle. key_row=0010 @001, then 0001 @010.
6. Assert rst mid-PRESS of code 7 → key_row=0000 next cycle, key_ready=1, no done pulse. A following code 5 behaves normally.

Source files
------------

// File: rtl/key_matrix_pkg.sv
// Shared definitions for the keypad scanner and the keypad emulator:
// key codes, column strobe patterns and the emulator FSM states.
package key_matrix_pkg;

  // Key codes
  localparam logic [3:0] SN = 4'd0;
  localparam logic [3:0] SA = 4'd1;   // '*'
  localparam logic [3:0] SS = 4'd2;   // '#'
  localparam logic [3:0] S0 = 4'd3;
  localparam logic [3:0] S1 = 4'd4;
  localparam logic [3:0] S2 = 4'd5;
  localparam logic [3:0] S3 = 4'd6;
  localparam logic [3:0] S4 = 4'd7;
  localparam logic [3:0] S5 = 4'd8;
  localparam logic [3:0] S6 = 4'd9;
  localparam logic [3:0] S7 = 4'd10;
  localparam logic [3:0] S8 = 4'd11;
  localparam logic [3:0] S9 = 4'd12;

  // Column strobes (one-hot, left to right)
  localparam logic [2:0] COL_L = 3'b100;
  localparam logic [2:0] COL_M = 3'b010;
  localparam logic [2:0] COL_R = 3'b001;

  // Emulator FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/key_code_map.sv
// Decodes a key code into the row/column one-hot pair where that key sits
// on the 3x4 matrix. Pause codes (0, 13..15) decode to all-zero with
// valid_key low.
import key_matrix_pkg::*;

module key_code_map (
  input  logic [3:0] code,
  output logic [3:0] row,
  output logic [2:0] col,
  output logic       valid_key
);

  // Matrix position lookup
  always_comb begin
    row       = 4'b0000;
    col       = 3'b000;
    valid_key = 1'b1;
    case (code)
      S1: begin row = 4'b1000; col = COL_L; end
      S2: begin row = 4'b1000; col = COL_M; end
      S3: begin row = 4'b1000; col = COL_R; end
      S4: begin row = 4'b0100; col = COL_L; end
      S5: begin row = 4'b0100; col = COL_M; end
      S6: begin row = 4'b0100; col = COL_R; end
      S7: begin row = 4'b0010; col = COL_L; end
      S8: begin row = 4'b0010; col = COL_M; end
      S9: begin row = 4'b0010; col = COL_R; end
      SA: begin row = 4'b0001; col = COL_L; end
      S0: begin row = 4'b0001; col = COL_M; end
      SS: begin row = 4'b0001; col = COL_R; end
      default: valid_key = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_matrix_emu.sv
// 3x4 keypad emulator. Accepts key codes over valid/ready, holds each key
// for HOLD_SCANS scanner rounds, then releases it for GAP_SCANS rounds.
// Row levels are gated combinationally from the live column strobe so the
// scanner sees them within the same half cycle it drives the column.
import key_matrix_pkg::*;

module key_matrix_emu #(
  parameter int unsigned HOLD_SCANS = 4,
  parameter int unsigned GAP_SCANS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] HOLD_CNT = HOLD_SCANS[7:0];
  localparam logic [7:0] GAP_CNT  = GAP_SCANS[7:0];

  logic [3:0] map_row;
  logic [2:0] map_col;
  logic       map_valid;

  state_t     state_reg;
  logic       pressed_reg;
  logic [2:0] prev_col_reg;
  logic [7:0] cnt_reg;
  logic [3:0] row_reg;
  logic [2:0] col_reg;
  logic       done_reg;

  logic       scan_tick;
  logic [7:0] cnt_inc;
  logic       col_hit;

  key_code_map u_map (
    .code      (key_code),
    .row       (map_row),
    .col       (map_col),
    .valid_key (map_valid)
  );

  // One tick per scanner round: the rising edge of the rightmost strobe
  assign scan_tick = (key_col == COL_R) && (prev_col_reg != COL_R);

  // Saturating increment; the == compare never wraps past the limit
  assign cnt_inc = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;

  // Press/release sequencing, tick counting and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      pressed_reg  <= 1'b0;
      prev_col_reg <= 3'b000;
      cnt_reg      <= 8'd0;
      row_reg      <= 4'b0000;
      col_reg      <= 3'b000;
      done_reg     <= 1'b0;
    end else begin
      prev_col_reg <= key_col;
      done_reg     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A tick coinciding with the transfer is deliberately not counted
          if (key_valid) begin
            row_reg <= map_row;
            col_reg <= map_col;
            cnt_reg <= 8'd0;
            if (map_valid) begin
              state_reg   <= ST_PRESS;
              pressed_reg <= 1'b1;
            end else begin
              state_reg <= ST_RELEASE;
            end
          end
        end
        ST_PRESS: begin
          if (scan_tick) begin
            if (cnt_inc == HOLD_CNT) begin
              state_reg   <= ST_RELEASE;
              cnt_reg     <= 8'd0;
              pressed_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end
        ST_RELEASE: begin
          if (scan_tick) begin
            if (cnt_inc == GAP_CNT) begin
              state_reg <= ST_IDLE;
              cnt_reg   <= 8'd0;
              done_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign key_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg == ST_PRESS) || (state_reg == ST_RELEASE);
  assign done      = done_reg;

  // A non-one-hot strobe can never equal the latched one-hot column
  assign col_hit = pressed_reg && (key_col == col_reg);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign key_row[gi] = col_hit & row_reg[gi];
    end
  endgenerate

endmodule
